// File: rtl/pixel_tx_serial_pkg.sv
// Shared types and constants for the pixel serial transmitter.
// PIXEL_TX_PARITY_EN adds an even-parity bit (8E1 instead of 8N1).
package pixel_tx_serial_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR   = 4'd1,
    ST_LOAD   = 4'd2,
    ST_START  = 4'd3,
    ST_DATA   = 4'd4,
`ifdef PIXEL_TX_PARITY_EN
    ST_PARITY = 4'd5,
`endif
    ST_STOP   = 4'd6,
    ST_NEXT   = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

  localparam int   CLK_DIV_DEF   = 434;
  localparam logic LINE_IDLE     = 1'b1;
  localparam int   BYTES_PER_PIX = 2;

endpackage

// File: rtl/tx_byte_8N1.sv
// Byte serializer: start bit, 8 data bits LSB first, stop bit.
// PIXEL_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module tx_byte_8N1
  import pixel_tx_serial_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_line,
  output logic       o_done,
  output logic [3:0] o_phase
);

  localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  state_t          r_ph;
  state_t          w_ph_nxt;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_sh;
  logic            r_line;
  logic            w_tick;
  logic            w_load;
`ifdef PIXEL_TX_PARITY_EN
  logic            r_par;
`endif

  assign w_tick  = (r_baud == BW'(CLK_DIV - 1));
  assign o_done  = (r_ph == ST_STOP) && w_tick;
  // a new byte may chain directly off the last stop-bit cycle
  assign w_load  = i_start && ((r_ph == ST_IDLE) || o_done);
  assign o_line  = r_line;
  assign o_phase = r_ph;

  always_comb begin
    w_ph_nxt = r_ph;
    unique case (r_ph)
      ST_IDLE:
        if (i_start) w_ph_nxt = ST_START;
      ST_START:
        if (w_tick) w_ph_nxt = ST_DATA;
      ST_DATA:
        if (w_tick && r_bit == 3'd7)
`ifdef PIXEL_TX_PARITY_EN
          w_ph_nxt = ST_PARITY;
      ST_PARITY:
        if (w_tick) w_ph_nxt = ST_STOP;
`else
          w_ph_nxt = ST_STOP;
`endif
      ST_STOP:
        if (w_tick)
          w_ph_nxt = i_start ? ST_START : ST_IDLE;
      default:
        w_ph_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ph   <= ST_IDLE;
      r_baud <= '0;
      r_bit  <= '0;
      r_sh   <= '0;
      r_line <= LINE_IDLE;
`ifdef PIXEL_TX_PARITY_EN
      r_par  <= 1'b0;
`endif
    end else begin
      r_ph <= w_ph_nxt;
      if (w_load) begin
        r_sh   <= i_byte;
        r_line <= 1'b0;
        r_baud <= '0;
`ifdef PIXEL_TX_PARITY_EN
        r_par  <= ^i_byte;
`endif
      end else if (r_ph != ST_IDLE) begin
        if (w_tick) begin
          r_baud <= '0;
          if (r_ph == ST_START) begin
            r_line <= r_sh[0];
          end else if (r_ph == ST_DATA) begin
            r_bit <= r_bit + 3'd1;
            r_sh  <= r_sh >> 1;
            if (r_bit == 3'd7)
`ifdef PIXEL_TX_PARITY_EN
              r_line <= r_par;
`else
              r_line <= LINE_IDLE;
`endif
            else
              r_line <= r_sh[1];
          end else begin
            r_line <= LINE_IDLE;
          end
        end else begin
          r_baud <= r_baud + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pixel_tx_serial.sv
// Frame sequencer: walks the pixel grid and sends each pixel as two bytes.
// Define PIXEL_TX_PARITY_EN for an 8E1 link (default 8N1).
module pixel_tx_serial
  import pixel_tx_serial_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int LINES   = 3,
  parameter int COLUMNS = 3,
  parameter int S_DATA  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              partida,
  input  logic [S_DATA-1:0] pixel_in,
  output logic [1:0]        addr_line,
  output logic [1:0]        addr_column,
  output logic              saida_serial,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  state_t     r_st;
  state_t     w_st_nxt;
  logic [1:0] r_line;
  logic [1:0] r_col;
  logic       r_hi;
  logic [7:0] r_lo;
  logic       w_last;
  logic       w_done;
  logic       w_tx_start;
  logic [7:0] w_byte;
  logic [3:0] w_phase;

  assign w_last = (r_line == 2'(LINES - 1)) &&
                  (r_col == 2'(COLUMNS - 1));

  // ST_START here means "byte engine busy"; the
  // engine's own phase is reported on db_estado
  assign w_tx_start = (r_st == ST_LOAD) ||
                      ((r_st == ST_START) && w_done && r_hi);
  assign w_byte = (r_st == ST_LOAD) ? pixel_in[15:8] : r_lo;

  tx_byte_8N1 #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clock   (clock),
    .reset   (reset),
    .i_start (w_tx_start),
    .i_byte  (w_byte),
    .o_line  (saida_serial),
    .o_done  (w_done),
    .o_phase (w_phase)
  );

  always_comb begin
    w_st_nxt = r_st;
    unique case (r_st)
      ST_IDLE:  if (partida) w_st_nxt = ST_ADDR;
      ST_ADDR:  w_st_nxt = ST_LOAD;
      ST_LOAD:  w_st_nxt = ST_START;
      ST_START: if (w_done && !r_hi) w_st_nxt = ST_NEXT;
      ST_NEXT:  w_st_nxt = w_last ? ST_DONE : ST_ADDR;
      ST_DONE:  w_st_nxt = ST_IDLE;
      default:  w_st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_st   <= ST_IDLE;
      r_line <= '0;
      r_col  <= '0;
      r_hi   <= 1'b0;
      r_lo   <= '0;
    end else begin
      r_st <= w_st_nxt;
      if (r_st == ST_IDLE && partida) begin
        r_line <= '0;
        r_col  <= '0;
        r_hi   <= 1'b1;
      end
      if (r_st == ST_LOAD)
        r_lo <= pixel_in[7:0];
      if (r_st == ST_START && w_done && r_hi)
        r_hi <= 1'b0;
      if (r_st == ST_NEXT && !w_last) begin
        r_hi <= 1'b1;
        if (r_col == 2'(COLUMNS - 1)) begin
          r_col  <= '0;
          r_line <= r_line + 2'd1;
        end else begin
          r_col <= r_col + 2'd1;
        end
      end
    end
  end

  assign addr_line   = r_line;
  assign addr_column = r_col;
  assign pronto      = (r_st == ST_DONE);
  assign ocupado     = (r_st != ST_IDLE) && (r_st != ST_DONE);
  assign db_estado   = (r_st == ST_START) ? w_phase : r_st;

endmodule

// File: tb/tb_pixel_tx_serial.sv
// Bench for pixel_tx_serial at CLK_DIV=4 with a registered 3x3 memory.
// Build with PIXEL_TX_PARITY_EN to check the 8E1 framing instead.
module tb_pixel_tx_serial;

  localparam int CD = 4;
`ifdef PIXEL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int BL = NB * CD;
  localparam int FRAME = 18 * BL + 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        partida;
  logic [15:0] rdata;
  logic [1:0]  addr_line;
  logic [1:0]  addr_column;
  logic        saida_serial;
  logic        ocupado;
  logic        pronto;
  logic [3:0]  db_estado;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int p_cnt   = 0;

  logic [15:0] mem [9];

  typedef struct {
    logic [15:0] pix;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [1:0]  ln;
    logic [1:0]  cl;
  } vec_t;
  vec_t tbl [9];

  pixel_tx_serial #(
    .CLK_DIV (CD),
    .LINES   (3),
    .COLUMNS (3),
    .S_DATA  (16)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .partida      (partida),
    .pixel_in     (rdata),
    .addr_line    (addr_line),
    .addr_column  (addr_column),
    .saida_serial (saida_serial),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pronto === 1'b1) p_cnt <= p_cnt + 1;
    rdata <= mem[int'(addr_line) * 3 + int'(addr_column)];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Finds a start bit, then samples every cycle of the frame and
  // demands each bit be stable for CD cycles.
  task automatic get_byte(input int tmo, output logic [7:0] d,
                          output int t0, output bit ok);
    int n;
    logic [10:0] fr;
    ok = 1'b1;
    n = 0;
    d = '0;
    t0 = -1;
    fr = '0;
    while (saida_serial !== 1'b0 && n < tmo) begin
      @(negedge clk);
      n++;
    end
    if (saida_serial !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    t0 = cyc;
    for (int b = 0; b < NB; b++) begin
      fr[b] = saida_serial;
      for (int k = 1; k < CD; k++) begin
        @(negedge clk);
        if (saida_serial !== fr[b]) ok = 1'b0;
      end
      if (b < NB - 1) @(negedge clk);
    end
    d = fr[8:1];
    if (fr[0] !== 1'b0 || fr[NB-1] !== 1'b1) ok = 1'b0;
`ifdef PIXEL_TX_PARITY_EN
    if (fr[9] !== ^d) ok = 1'b0;
`endif
  endtask

  task automatic decode(input int c_acc, input int nb,
                        output int tlast);
    logic [7:0] d;
    int t0, tprev, texp;
    bit ok;
    tprev = 0;
    for (int k = 0; k < nb; k++) begin
      get_byte(3 * BL, d, t0, ok);
      chk($sformatf("byte%0d value", k), 32'(d),
          (k % 2 == 1) ? 32'(tbl[k/2].lo) : 32'(tbl[k/2].hi));
      chk($sformatf("byte%0d framing", k), 32'(ok), 32'd1);
      if (k == 0)          texp = c_acc + 3;
      else if (k % 2 == 1) texp = tprev + BL;
      else                 texp = tprev + BL + 3;
      chk($sformatf("byte%0d start cycle", k), t0, texp);
      chk($sformatf("byte%0d addr_line", k),
          32'(addr_line), 32'(tbl[k/2].ln));
      chk($sformatf("byte%0d addr_column", k),
          32'(addr_column), 32'(tbl[k/2].cl));
      tprev = t0;
    end
    tlast = tprev;
  endtask

  task automatic wait_pronto(input int exp_c, output int pc);
    int n;
    n = 0;
    while (pronto !== 1'b1 && n < 2 * BL) begin
      @(negedge clk);
      n++;
    end
    pc = cyc;
    chk("pronto cycle", pc, exp_c);
    chk("ocupado with pronto", 32'(ocupado), 32'd0);
    chk("final addr_line", 32'(addr_line), 32'd2);
    chk("final addr_column", 32'(addr_column), 32'd2);
  endtask

  initial begin
    int c, tl, pc, p0, n, lows, t0;
    logic [7:0] d;
    bit ok;

    for (int i = 0; i < 9; i++) begin
      tbl[i].pix = 16'hA500 + 16'(i);
      tbl[i].hi  = 8'hA5;
      tbl[i].lo  = 8'(i);
      tbl[i].ln  = 2'(i / 3);
      tbl[i].cl  = 2'(i % 3);
      mem[i]     = tbl[i].pix;
    end

    reset = 1'b1;
    partida = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset saida_serial", 32'(saida_serial), 32'd1);
    chk("reset ocupado", 32'(ocupado), 32'd0);
    chk("reset pronto", 32'(pronto), 32'd0);
    chk("reset addr_line", 32'(addr_line), 32'd0);
    chk("reset addr_column", 32'(addr_column), 32'd0);
    chk("reset db_estado", 32'(db_estado), 32'd0);

    // full frame, single partida pulse
    p0 = p_cnt;
    c = cyc;
    partida = 1'b1;
    @(negedge clk);
    partida = 1'b0;
    chk("f1 ocupado in ADDR", 32'(ocupado), 32'd1);
    chk("f1 db_estado ADDR", 32'(db_estado), 32'd1);
    decode(c, 18, tl);
    wait_pronto(c + 3 + FRAME + 1, pc);
    @(negedge clk);
    chk("f1 back in IDLE", 32'(db_estado), 32'd0);
    repeat (20) @(negedge clk);
    chk("f1 pronto count", p_cnt, p0 + 1);

    // pixel 0 = 5A3C, then reset in DATA of the 7th byte
    mem[0] = 16'h5A3C;
    tbl[0].hi = 8'h5A;
    tbl[0].lo = 8'h3C;
    p0 = p_cnt;
    c = cyc;
    partida = 1'b1;
    @(negedge clk);
    partida = 1'b0;
    decode(c, 6, tl);
    n = 0;
    while (saida_serial !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("byte6 start cycle", cyc, tl + BL + 3);
    repeat (6) @(negedge clk);
    chk("byte6 in DATA", 32'(db_estado), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset saida_serial", 32'(saida_serial), 32'd1);
    chk("midreset ocupado", 32'(ocupado), 32'd0);
    chk("midreset db_estado", 32'(db_estado), 32'd0);
    reset = 1'b0;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (saida_serial !== 1'b1) lows++;
    end
    chk("idle after reset line", lows, 0);
    chk("no pronto after reset", p_cnt, p0);

    // partida held high: one frame, next one starts right after
    p0 = p_cnt;
    c = cyc;
    partida = 1'b1;
    @(negedge clk);
    chk("f3 restart addr_line", 32'(addr_line), 32'd0);
    chk("f3 restart addr_column", 32'(addr_column), 32'd0);
    decode(c, 18, tl);
    wait_pronto(c + 3 + FRAME + 1, pc);
    get_byte(20, d, t0, ok);
    chk("f4 start cycle", t0, pc + 4);
    chk("f4 first byte", 32'(d), 32'h5A);
    reset = 1'b1;
    partida = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("f3 pronto count", p_cnt, p0 + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
